// File: rtl/asrm_ram_bridge.sv
// Bridges the ASRM fixed-timing RAM port onto a req/ack memory bus, with a one-entry read buffer.
// Optional ack-timeout watchdog enabled by defining ASRM_BRIDGE_TIMEOUT_EN.
module asrm_ram_bridge #(
  parameter int wordsize       = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_wait,
  output logic                bus_req,
  output logic                bus_we,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_wdata,
  input  logic [wordsize-1:0] bus_rdata,
  input  logic                bus_ack,
  output logic                bus_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDONE = 2'd2
  } state_t;

  // Counter value seen in the last REQ cycle before the access is given up.
  localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);

  state_t              state_q, state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [wordsize-1:0] buf_addr_q, buf_addr_d;
  logic [wordsize-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [wordsize-1:0] bus_addr_q, bus_addr_d;
  logic [wordsize-1:0] bus_wdata_q, bus_wdata_d;
  logic                need_write, need_read;

`ifdef ASRM_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`else
  logic [7:0] unused_to_last;
  assign unused_to_last = TO_LAST;
`endif

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
`ifdef ASRM_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    need_write = cpu_write_en;
    need_read  = !cpu_write_en && (!buf_valid_q || (cpu_addr != buf_addr_q));

    case (state_q)
      IDLE: begin
        if (need_write || need_read) begin
          bus_addr_d  = cpu_addr;
          bus_wdata_d = cpu_wdata;
          bus_we_d    = cpu_write_en;
          bus_req_d   = 1'b1;
          state_d     = REQ;
`ifdef ASRM_BRIDGE_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            cpu_rdata_d = bus_rdata;
            buf_addr_d  = bus_addr_q;
            buf_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Write-through keeps the buffered read value coherent.
            if (buf_valid_q && (bus_addr_q == buf_addr_q)) begin
              cpu_rdata_d = bus_wdata_q;
            end
            state_d = WDONE;
          end
        end
`ifdef ASRM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          bus_req_d = 1'b0;
          timeout_d = 1'b1;
          if (!bus_we_q) begin
            cpu_rdata_d = '0;
            buf_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = WDONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      WDONE: begin
        // A held write_en must not trigger a second bus write.
        if (!cpu_write_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      cpu_rdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

`ifdef ASRM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus_timeout = timeout_q;
`else
  assign bus_timeout = 1'b0;
`endif

  // Stall is combinational so it appears in the same cycle the address changes.
  assign cpu_wait = reset && (((state_q == IDLE) && (need_write || need_read)) ||
                              (state_q == REQ));

  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
